// File: rtl/traffic_pkg.sv
// Shared lamp codes, FSM state encoding and the per-lamp decode used by the
// traffic phase sequencer.
package traffic_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef enum logic [2:0] {
        ALL_RED = 3'd0,
        GREEN   = 3'd1,
        YELLOW  = 3'd2,
        PREEMPT = 3'd3,
        FLASH   = 3'd4
    } state_t;

    // in_phase: the signal is in the current phase's green mask.
    function automatic logic [2:0] lamp_code(input state_t st, input logic in_phase,
                                             input logic flash_on);
        logic [2:0] code;
        case (st)
            GREEN, PREEMPT: code = in_phase ? GRN : RED;
            YELLOW:         code = in_phase ? YEL : RED;
            FLASH:          code = flash_on ? YEL : OFF;
            default:        code = RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/traffic_next_phase.sv
// Round-robin next-phase picker: first eligible phase after the current one,
// with wrap-around. Phase 0 is always eligible, so a result always exists.
module traffic_next_phase #(
    parameter int NUM_PHASES = 4
) (
    input  logic [$clog2(NUM_PHASES)-1:0] phase,
    input  logic [NUM_PHASES-1:0]         demand,
    output logic [$clog2(NUM_PHASES)-1:0] next_phase
);
    localparam int PW = $clog2(NUM_PHASES);

    logic [NUM_PHASES-1:0] eligible;
    logic [PW:0]           sum;
    logic [PW-1:0]         cand;
    logic                  found;

    assign eligible = demand | NUM_PHASES'(1);

    always_comb begin
        next_phase = '0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        // Step k = NUM_PHASES lands back on the current phase, closing the ring.
        for (int k = 1; k <= NUM_PHASES; k++) begin
            sum = {1'b0, phase} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_PHASES)) begin
                sum = sum - (PW+1)'(NUM_PHASES);
            end
            cand = sum[PW-1:0];
            if (!found && eligible[cand]) begin
                next_phase = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Traffic signal phase sequencer: green/yellow/all-red cycling with demand
// skipping, emergency preemption and flash mode.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int NUM_SIG    = 4,
    parameter int CNT_W      = 8,
    parameter int YELLOW_T   = 5,
    parameter int ALLRED_T   = 2,
    parameter int MIN_GREEN  = 3,
    parameter int FLASH_T    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_PHASES*CNT_W-1:0]     green_time,
    input  logic [NUM_PHASES*NUM_SIG-1:0]   green_mask,
    input  logic [NUM_PHASES-1:0]           demand,
    input  logic                            preempt_req,
    input  logic [$clog2(NUM_PHASES)-1:0]   preempt_phase,
    input  logic                            flash_req,
    output logic [NUM_SIG*3-1:0]            lights,
    output logic [$clog2(NUM_PHASES)-1:0]   phase_id,
    output logic [2:0]                      state_o,
    output logic                            phase_done
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);
    localparam logic [CNT_W:0]   MIN_GREEN_W = (CNT_W+1)'(MIN_GREEN);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  dur_reg;
    logic [PW-1:0]     phase_reg;
    logic              pending_reg;
    logic              force_p0_reg;
    logic              flash_on_reg;

    logic [PW-1:0]       next_phase;
    logic [CNT_W-1:0]    gt_arr   [NUM_PHASES];
    logic [NUM_SIG-1:0]  mask_arr [NUM_PHASES];
    logic [NUM_SIG-1:0]  mask_sel;
    logic                hold_green;
    logic                timer_done;
    logic                preempt_cut;
    logic                green_end;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_unpack
            assign gt_arr[gi]   = green_time[gi*CNT_W +: CNT_W];
            assign mask_arr[gi] = green_mask[gi*NUM_SIG +: NUM_SIG];
        end
    endgenerate

    traffic_next_phase #(
        .NUM_PHASES (NUM_PHASES)
    ) u_next_phase (
        .phase      (phase_reg),
        .demand     (demand),
        .next_phase (next_phase)
    );

    function automatic logic [CNT_W-1:0] green_len(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    // Preemption toward the phase already green just freezes it as PREEMPT.
    assign hold_green  = preempt_req && (phase_reg == preempt_phase);
    assign timer_done  = (cnt_reg == dur_reg - 1'b1);
    assign preempt_cut = preempt_req && !hold_green &&
                         (({1'b0, cnt_reg} + 1'b1) >= MIN_GREEN_W);
    assign green_end   = timer_done || preempt_cut;

    assign phase_done = (state_reg == GREEN) && enable && !rst && !flash_req &&
                        !hold_green && green_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ALL_RED;
            cnt_reg      <= '0;
            dur_reg      <= CNT_W'(1);
            phase_reg    <= '0;
            pending_reg  <= 1'b0;
            force_p0_reg <= 1'b1;
            flash_on_reg <= 1'b0;
        end else if (flash_req) begin
            if (state_reg != FLASH) begin
                state_reg    <= FLASH;
                cnt_reg      <= '0;
                flash_on_reg <= 1'b1;
                pending_reg  <= 1'b0;
            end else if (cnt_reg == FLASH_LAST) begin
                cnt_reg      <= '0;
                flash_on_reg <= !flash_on_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else if (state_reg == FLASH) begin
            // Leaving flash restarts the cycle cleanly from phase 0.
            state_reg    <= ALL_RED;
            cnt_reg      <= '0;
            force_p0_reg <= 1'b1;
            flash_on_reg <= 1'b0;
        end else if (enable) begin
            case (state_reg)
                ALL_RED: begin
                    if (preempt_req) pending_reg <= 1'b1;
                    if (cnt_reg == ALLRED_LAST) begin
                        cnt_reg <= '0;
                        if (force_p0_reg) begin
                            state_reg    <= GREEN;
                            phase_reg    <= '0;
                            dur_reg      <= green_len(gt_arr[0]);
                            force_p0_reg <= 1'b0;
                        end else if (pending_reg || preempt_req) begin
                            state_reg   <= PREEMPT;
                            phase_reg   <= preempt_phase;
                            pending_reg <= 1'b0;
                        end else begin
                            state_reg <= GREEN;
                            phase_reg <= next_phase;
                            dur_reg   <= green_len(gt_arr[next_phase]);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GREEN: begin
                    if (hold_green) begin
                        state_reg <= PREEMPT;
                    end else if (green_end) begin
                        state_reg <= YELLOW;
                        cnt_reg   <= '0;
                        if (preempt_cut) pending_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                YELLOW: begin
                    if (preempt_req) pending_reg <= 1'b1;
                    if (cnt_reg == YELLOW_LAST) begin
                        state_reg <= ALL_RED;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                PREEMPT: begin
                    if (!preempt_req) begin
                        state_reg <= YELLOW;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ALL_RED;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign mask_sel = mask_arr[phase_reg];

    generate
        for (gi = 0; gi < NUM_SIG; gi++) begin : g_lamp
            assign lights[gi*3 +: 3] = lamp_code(state_reg, mask_sel[gi], flash_on_reg);
        end
    endgenerate

    assign state_o  = state_reg;
    assign phase_id = phase_reg;

endmodule
